reg_seq_ctrl: RTL and testbench

- Instruction sequencer for the 8x16 register file / ALU / shifter datapath.
- Latches a 16-bit instruction on a start strobe, decodes it, and drives the datapath controls cycle by cycle: regfile readnum/writenum/write, A/B/C/status load enables, operand selects, ALU op, shift and writeback select.
- Signals completion with a wait flag and waits for the next start.

---
 rtl/reg_seq_ctrl_pkg.sv | 138 +++++++++++++
 rtl/reg_seq_ctrl_instr_dec.sv | 30 +++
 rtl/reg_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_reg_seq_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_seq_ctrl_pkg.sv
// Shared definitions for the register-file sequencer.
// Contents: instruction field positions, opcode/op constants, ALU and
// writeback-select codes, the FSM state type, the control-output bundle,
// and the function that maps (state, decoded instruction) to controls.
package reg_seq_ctrl_pkg;

    localparam int IW = 16;

    // Field LSB positions inside the instruction word
    localparam int OPC_LSB = 13;  // ir[15:13]
    localparam int OP_LSB  = 11;  // ir[12:11]
    localparam int RN_LSB  = 8;   // ir[10:8]
    localparam int RD_LSB  = 5;   // ir[7:5]
    localparam int SH_LSB  = 3;   // ir[4:3]
    localparam int RM_LSB  = 0;   // ir[2:0]

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b01;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WIMM   = 3'd2,
        S_GETA   = 3'd3,
        S_GETB   = 3'd4,
        S_EXEC   = 3'd5,
        S_WRB    = 3'd6
    } state_t;

    typedef struct packed {
        logic       w;
        logic       bad;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic [1:0] vsel;
    } ctrl_t;

    function automatic logic is_movi(input logic [2:0] opcode, input logic [1:0] op);
        return (opcode == OPC_MOV) && (op == OP_MOVI);
    endfunction

    function automatic logic is_movr(input logic [2:0] opcode, input logic [1:0] op);
        return (opcode == OPC_MOV) && (op == OP_MOVR);
    endfunction

    function automatic logic is_alu(input logic [2:0] opcode);
        return opcode == OPC_ALU;
    endfunction

    // ALU instruction op field to ALU operation code
    function automatic logic [1:0] alu_for(input logic [1:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_CMP:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            default: return ALU_MVN;
        endcase
    endfunction

    // Value of every control output while the FSM sits in state st
    function automatic ctrl_t ctrl_decode(
        input state_t     st,
        input logic       legal,
        input logic       movr,
        input logic       cmp,
        input logic [1:0] op,
        input logic [2:0] rn,
        input logic [2:0] rd,
        input logic [2:0] rm,
        input logic [1:0] sh
    );
        ctrl_t c;
        c       = '0;
        c.shift = sh;
        case (st)
            S_WAIT:   c.w = 1'b1;
            S_DECODE: c.bad = ~legal;
            S_WIMM: begin
                c.writenum = rn;
                c.vsel     = VSEL_IMM;
                c.write    = 1'b1;
            end
            S_GETA: begin
                c.readnum = rn;
                c.loada   = 1'b1;
            end
            S_GETB: begin
                c.readnum = rm;
                c.loadb   = 1'b1;
            end
            S_EXEC: begin
                c.asel   = movr;
                c.alu_op = movr ? ALU_ADD : alu_for(op);
                c.loads  = cmp;
                c.loadc  = ~cmp;
            end
            S_WRB: begin
                c.writenum = rd;
                c.vsel     = VSEL_C;
                c.write    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctrl_t ctrl_reset();
        ctrl_t c;
        c   = '0;
        c.w = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/reg_seq_ctrl_instr_dec.sv
// Combinational instruction field decoder.
// Ports: ir (instruction word) in; opcode, op, rn, rd, sh, rm (raw fields),
// sximm8 (ir[7:0] sign-extended to DW) and legal (instruction is in the
// supported subset) out.
module reg_seq_ctrl_instr_dec
    import reg_seq_ctrl_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [IW-1:0] ir,
    output logic [2:0]    opcode,
    output logic [1:0]    op,
    output logic [2:0]    rn,
    output logic [2:0]    rd,
    output logic [1:0]    sh,
    output logic [2:0]    rm,
    output logic [DW-1:0] sximm8,
    output logic          legal
);

    assign opcode = ir[OPC_LSB +: 3];
    assign op     = ir[OP_LSB +: 2];
    assign rn     = ir[RN_LSB +: 3];
    assign rd     = ir[RD_LSB +: 3];
    assign sh     = ir[SH_LSB +: 2];
    assign rm     = ir[RM_LSB +: 3];
    assign sximm8 = {{(DW-8){ir[7]}}, ir[7:0]};
    assign legal  = is_movi(opcode, op) | is_movr(opcode, op) | is_alu(opcode);

endmodule

// File: rtl/reg_seq_ctrl.sv
// Instruction sequencer for the 8x16 register file / ALU / shifter datapath.
// Ports: clk, rst_n (async active-low), s (start strobe), in (instruction);
// w (idle), bad (illegal instruction in DECODE), readnum/writenum/write
// (regfile), loada/loadb/loadc/loads (register loads), asel/bsel/shift/
// alu_op/vsel (datapath selects), sximm8 (sign-extended immediate),
// state_dbg (current FSM state, for observation only).
//
// Handshake: w is the ready and s the valid. An instruction is accepted on
// any rising edge where w = 1 and s = 1; s and in are ignored whenever
// w = 0. w returns to 1 on the edge that completes the instruction, so an
// s held high starts the next instruction one cycle later.
module reg_seq_ctrl
    import reg_seq_ctrl_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s,
    input  logic [IW-1:0] in,
    output logic          w,
    output logic          bad,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    shift,
    output logic [1:0]    alu_op,
    output logic [1:0]    vsel,
    output logic [DW-1:0] sximm8,
    output state_t        state_dbg
);

    state_t        state, state_n;
    logic [IW-1:0] ir, ir_n;
    ctrl_t         ctrl_q;
    logic [DW-1:0] sximm8_q;

    logic [2:0]    opcode, rn, rd, rm;
    logic [1:0]    op, sh;
    logic [DW-1:0] sximm8_n;
    logic          legal, movi, movr, cmp, mvn;

    // The decoder looks at the ir value of the next cycle. Outputs are
    // registered from (state_n, ir_n) so they stay Moore functions of the
    // registered state and ir. ir only changes leaving WAIT, so in every
    // state that branches on the instruction ir_n equals ir.
    reg_seq_ctrl_instr_dec #(.DW(DW)) u_dec (
        .ir     (ir_n),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm8 (sximm8_n),
        .legal  (legal)
    );

    assign movi = is_movi(opcode, op);
    assign movr = is_movr(opcode, op);
    assign cmp  = is_alu(opcode) && (op == OP_CMP);
    assign mvn  = is_alu(opcode) && (op == OP_MVN);

    always_comb begin
        state_n = S_WAIT;
        ir_n    = ir;
        case (state)
            S_WAIT: begin
                if (s) begin
                    state_n = S_DECODE;
                    ir_n    = in;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_DECODE: begin
                if (!legal)            state_n = S_WAIT;
                else if (movi)         state_n = S_WIMM;
                else if (movr || mvn)  state_n = S_GETB;
                else                   state_n = S_GETA;
            end
            S_WIMM: state_n = S_WAIT;
            S_GETA: state_n = S_GETB;
            S_GETB: state_n = S_EXEC;
            S_EXEC: state_n = cmp ? S_WAIT : S_WRB;
            S_WRB:  state_n = S_WAIT;
            default: state_n = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_WAIT;
            ir       <= '0;
            ctrl_q   <= ctrl_reset();
            sximm8_q <= '0;
        end else begin
            state    <= state_n;
            ir       <= ir_n;
            ctrl_q   <= ctrl_decode(state_n, legal, movr, cmp, op, rn, rd, rm, sh);
            // Always equals sign-extended ir[7:0] of the registered ir
            sximm8_q <= sximm8_n;
        end
    end

    assign w         = ctrl_q.w;
    assign bad       = ctrl_q.bad;
    assign readnum   = ctrl_q.readnum;
    assign writenum  = ctrl_q.writenum;
    assign write     = ctrl_q.write;
    assign loada     = ctrl_q.loada;
    assign loadb     = ctrl_q.loadb;
    assign loadc     = ctrl_q.loadc;
    assign loads     = ctrl_q.loads;
    assign asel      = ctrl_q.asel;
    assign bsel      = ctrl_q.bsel;
    assign shift     = ctrl_q.shift;
    assign alu_op    = ctrl_q.alu_op;
    assign vsel      = ctrl_q.vsel;
    assign sximm8    = sximm8_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_reg_seq_ctrl.sv
module tb_reg_seq_ctrl;
  import reg_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s;
  logic [15:0] in;
  logic        w, bad, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, alu_op, vsel;
  logic [15:0] sximm8;
  state_t      state_dbg;

  int checks   = 0;
  int failures = 0;

  reg_seq_ctrl #(.DW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (s),
    .in        (in),
    .w         (w),
    .bad       (bad),
    .readnum   (readnum),
    .writenum  (writenum),
    .write     (write),
    .loada     (loada),
    .loadb     (loadb),
    .loadc     (loadc),
    .loads     (loads),
    .asel      (asel),
    .bsel      (bsel),
    .shift     (shift),
    .alu_op    (alu_op),
    .vsel      (vsel),
    .sximm8    (sximm8),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Observed vector: state, w, bad, readnum, writenum, write, loada, loadb,
  // loadc, loads, asel, bsel, shift, alu_op, vsel, sximm8
  logic [39:0] act;
  assign act = {state_dbg, w, bad, readnum, writenum, write, loada, loadb,
                loadc, loads, asel, bsel, shift, alu_op, vsel, sximm8};

  function automatic logic [39:0] pk(state_t st, logic ew, logic eb,
      logic [2:0] rn, logic [2:0] wn, logic wr, logic la, logic lb,
      logic lc, logic ls, logic as, logic [1:0] sh, logic [1:0] alu,
      logic [1:0] vs, logic [15:0] imm);
    return {st, ew, eb, rn, wn, wr, la, lb, lc, ls, as, 1'b0, sh, alu, vs, imm};
  endfunction

  function automatic logic [39:0] e_wait(logic [1:0] sh, logic [15:0] imm);
    return pk(S_WAIT, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, sh, 2'b00, 2'b00, imm);
  endfunction
  function automatic logic [39:0] e_dec(logic eb, logic [1:0] sh, logic [15:0] imm);
    return pk(S_DECODE, 0, eb, 0, 0, 0, 0, 0, 0, 0, 0, sh, 2'b00, 2'b00, imm);
  endfunction
  function automatic logic [39:0] e_wimm(logic [2:0] wn, logic [1:0] sh, logic [15:0] imm);
    return pk(S_WIMM, 0, 0, 0, wn, 1, 0, 0, 0, 0, 0, sh, 2'b00, 2'b01, imm);
  endfunction
  function automatic logic [39:0] e_geta(logic [2:0] rn, logic [1:0] sh, logic [15:0] imm);
    return pk(S_GETA, 0, 0, rn, 0, 0, 1, 0, 0, 0, 0, sh, 2'b00, 2'b00, imm);
  endfunction
  function automatic logic [39:0] e_getb(logic [2:0] rm, logic [1:0] sh, logic [15:0] imm);
    return pk(S_GETB, 0, 0, rm, 0, 0, 0, 1, 0, 0, 0, sh, 2'b00, 2'b00, imm);
  endfunction
  function automatic logic [39:0] e_exec(logic as, logic [1:0] alu, logic is_cmp,
      logic [1:0] sh, logic [15:0] imm);
    return pk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, ~is_cmp, is_cmp, as, sh, alu, 2'b00, imm);
  endfunction
  function automatic logic [39:0] e_wrb(logic [2:0] wn, logic [1:0] sh, logic [15:0] imm);
    return pk(S_WRB, 0, 0, 0, wn, 1, 0, 0, 0, 0, 0, sh, 2'b00, 2'b00, imm);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        s;
    logic [15:0] in;
    logic [39:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic vs, logic [15:0] vin, logic [39:0] vexp);
    vec_t v;
    v.s   = vs;
    v.in  = vin;
    v.exp = vexp;
    vecs.push_back(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // s = 0 rows drive junk on in: the sequencer must ignore it
  task automatic drive(logic vs, logic [15:0] vin);
    s  = vs;
    in = vs ? vin : 16'($urandom_range(0, 65535));
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(string name, logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    rst_n = 1'b0;
    s     = 1'b0;
    in    = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset", e_wait(2'b00, 16'h0000));

    // MOV R0,#7
    add(1, 16'hD007, e_dec(0, 2'b00, 16'h0007));
    add(0, 16'h0000, e_wimm(3'd0, 2'b00, 16'h0007));
    add(0, 16'h0000, e_wait(2'b00, 16'h0007));
    // MOV R1,#-2; s raised early (ignored in WIMM) and held into WAIT
    add(1, 16'hD1FE, e_dec(0, 2'b11, 16'hFFFE));
    add(0, 16'h0000, e_wimm(3'd1, 2'b11, 16'hFFFE));
    add(1, 16'hA140, e_wait(2'b11, 16'hFFFE));
    // ADD R2,R1,R0 started back-to-back
    add(1, 16'hA140, e_dec(0, 2'b00, 16'h0040));
    add(0, 16'h0000, e_geta(3'd1, 2'b00, 16'h0040));
    add(0, 16'h0000, e_getb(3'd0, 2'b00, 16'h0040));
    add(0, 16'h0000, e_exec(0, 2'b00, 0, 2'b00, 16'h0040));
    add(0, 16'h0000, e_wrb(3'd2, 2'b00, 16'h0040));
    add(0, 16'h0000, e_wait(2'b00, 16'h0040));
    // CMP R1,R0; s/in poked mid-instruction must be ignored
    add(1, 16'hA900, e_dec(0, 2'b00, 16'h0000));
    add(1, 16'hFFFF, e_geta(3'd1, 2'b00, 16'h0000));
    add(0, 16'h0000, e_getb(3'd0, 2'b00, 16'h0000));
    add(0, 16'h0000, e_exec(0, 2'b01, 1, 2'b00, 16'h0000));
    add(0, 16'h0000, e_wait(2'b00, 16'h0000));
    // MOV R3,R0,LSL#1
    add(1, 16'hC068, e_dec(0, 2'b01, 16'h0068));
    add(0, 16'h0000, e_getb(3'd0, 2'b01, 16'h0068));
    add(0, 16'h0000, e_exec(1, 2'b00, 0, 2'b01, 16'h0068));
    add(0, 16'h0000, e_wrb(3'd3, 2'b01, 16'h0068));
    add(0, 16'h0000, e_wait(2'b01, 16'h0068));
    // MVN R4,R5
    add(1, 16'hB885, e_dec(0, 2'b00, 16'hFF85));
    add(0, 16'h0000, e_getb(3'd5, 2'b00, 16'hFF85));
    add(0, 16'h0000, e_exec(0, 2'b11, 0, 2'b00, 16'hFF85));
    add(0, 16'h0000, e_wrb(3'd4, 2'b00, 16'hFF85));
    add(0, 16'h0000, e_wait(2'b00, 16'hFF85));
    // AND R6,R7,R2,LSR#1
    add(1, 16'hB7D2, e_dec(0, 2'b10, 16'hFFD2));
    add(0, 16'h0000, e_geta(3'd7, 2'b10, 16'hFFD2));
    add(0, 16'h0000, e_getb(3'd2, 2'b10, 16'hFFD2));
    add(0, 16'h0000, e_exec(0, 2'b10, 0, 2'b10, 16'hFFD2));
    add(0, 16'h0000, e_wrb(3'd6, 2'b10, 16'hFFD2));
    add(0, 16'h0000, e_wait(2'b10, 16'hFFD2));
    // Immediate sign boundaries: #-128 to R2, #127 to R3
    add(1, 16'hD280, e_dec(0, 2'b00, 16'hFF80));
    add(0, 16'h0000, e_wimm(3'd2, 2'b00, 16'hFF80));
    add(0, 16'h0000, e_wait(2'b00, 16'hFF80));
    add(1, 16'hD37F, e_dec(0, 2'b11, 16'h007F));
    add(0, 16'h0000, e_wimm(3'd3, 2'b11, 16'h007F));
    add(0, 16'h0000, e_wait(2'b11, 16'h007F));
    // Illegal encodings: bad for one DECODE cycle, then straight back to WAIT
    add(1, 16'hE000, e_dec(1, 2'b00, 16'h0000));
    add(0, 16'h0000, e_wait(2'b00, 16'h0000));
    add(0, 16'h0000, e_wait(2'b00, 16'h0000));
    add(1, 16'hC800, e_dec(1, 2'b00, 16'h0000));
    add(0, 16'h0000, e_wait(2'b00, 16'h0000));
    add(1, 16'hD800, e_dec(1, 2'b00, 16'h0000));
    add(0, 16'h0000, e_wait(2'b00, 16'h0000));

    // Release away from the clock edge; first vector starts on the next edge
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].s, vecs[i].in);
      tick();
      check($sformatf("vec%0d_in%h", i, vecs[i].in), vecs[i].exp);
    end

    // Reset during EXEC of ADD R2,R1,R0
    drive(1, 16'hA140);
    tick();
    drive(0, 16'h0000);
    check("rst_seq_dec", e_dec(0, 2'b00, 16'h0040));
    tick();
    tick();
    tick();
    check("rst_seq_exec", e_exec(0, 2'b00, 0, 2'b00, 16'h0040));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", e_wait(2'b00, 16'h0000));
    drive(1, 16'hA140);
    tick();
    check("rst_held", e_wait(2'b00, 16'h0000));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(0, 16'h0000);
    check("post_rst_dec", e_dec(0, 2'b00, 16'h0040));
    tick();
    check("post_rst_geta", e_geta(3'd1, 2'b00, 16'h0040));
    tick();
    check("post_rst_getb", e_getb(3'd0, 2'b00, 16'h0040));
    tick();
    check("post_rst_exec", e_exec(0, 2'b00, 0, 2'b00, 16'h0040));
    tick();
    check("post_rst_wrb", e_wrb(3'd2, 2'b00, 16'h0040));
    tick();
    check("post_rst_wait", e_wait(2'b00, 16'h0040));

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
